uart_autobaud_ctrl: RTL and testbench
=====================================

// Module: uart_autobaud_ctrl
// PURPOSE
// - Configuration controller for uart_rx: measures the baud rate from a 0x55 sync character on RX,
//   computes clocks-per-bit, drives uart_rx.prescaler_in, and holds uart_rx in reset until locked.
// - Monitors uart_rx framing_error / rx_ready while locked; drops lock and recalibrates on repeated errors.
// - Sits between the raw RX pin and uart_rx; uart_baud_gen and uart_rx themselves are unchanged.
// PARAMETERS
// - PRESCALER_W        21    width of prescaler_out; matches uart_rx prescaler_in
// - DEFAULT_PRESCALER  104   prescaler_out after reset (12 MHz / 115200)
// - MIN_PRESCALER      16    smallest accepted clocks-per-bit; smaller result -> calibration fail
// - IDLE_CYCLES        64    RX must be high this many consecutive cycles before a start edge is accepted
// - ERR_LIMIT          3     consecutive framing errors that drop lock
// PORTS
// - CLK            in   1            system clock
// - rst_n          in   1            reset, synchronous, active-low
// - RX             in   1            raw asynchronous serial line (also wired to uart_rx.RX)
// - recal          in   1            1-cycle pulse: abandon current state, go to HUNT
// - rx_ready       in   1            from uart_rx: byte received
// - framing_error  in   1            from uart_rx: level, high while uart_rx flags an error
// - prescaler_out  out  PRESCALER_W  to uart_rx.prescaler_in: clocks per bit
// - rx_rst_n       out  1            to uart_rx.rst_n: 0 while not locked
// - locked         out  1            1 = prescaler valid, uart_rx running
// - calib_done     out  1            1-cycle pulse on successful calibration
// - calib_fail     out  1            1-cycle pulse on rejected calibration attempt
// BEHAVIOUR
// - Reset: prescaler_out=DEFAULT_PRESCALER, rx_rst_n=0, locked=0, calib_done=0, calib_fail=0, state=HUNT.
// - RX goes through a 3-flop synchronizer; fall/rise = one-cycle edge strobes on the synchronized signal.
// - 0x55 LSB-first gives falling edges at bit times 0,2,4,6,8 -> edge1..edge5 span exactly 8 bit times.
// - Counter cnt: PRESCALER_W+3 bits, saturating; interval regs d0 (first), d (current), both cnt width.
// - HUNT: idle_cnt counts consecutive high cycles (clears on low); on fall with idle_cnt>=IDLE_CYCLES:
//   cnt<=1, edge_n<=1, -> MEASURE. Falls with insufficient idle ignored.
// - MEASURE: cnt increments every cycle; on each fall: edge_n++, interval = cnt - last_edge_cnt;
//   edge 2: d0<=interval; edges 3..5: reject if |interval-d0| > d0>>2 (+-25%).
//   On edge 5: prescaler_cand <= cnt>>3 (total span /8, truncating) -> WAIT_RISE.
// - WAIT_RISE: on rise (end of bit 7) start half-bit timer = prescaler_cand>>1 -> STOP_CHECK.
// - STOP_CHECK: RX must stay high for the half-bit; on expiry: if prescaler_cand<MIN_PRESCALER or
//   cand exceeds 2^PRESCALER_W-1 -> fail; else prescaler_out<=cand, locked<=1, rx_rst_n<=1,
//   calib_done pulse -> LOCKED. A fall during the half-bit -> fail.
// - Fail (any reject, cnt saturation timeout, stop violation): calib_fail pulse, prescaler_out unchanged,
//   locked=0, rx_rst_n=0 -> HUNT with idle_cnt=0.
// - LOCKED: err_cnt increments on rising edge of framing_error (registered copy); clears on rx_ready;
//   on err_cnt reaching ERR_LIMIT: locked<=0, rx_rst_n<=0 -> HUNT; prescaler_out keeps last value.
// - framing_error rise and rx_ready same cycle: rx_ready wins (err_cnt<=0).
// - recal: from any state, next cycle state=HUNT, locked=0, rx_rst_n=0, no calib_fail pulse.
// - recal with rst_n low: reset wins. Reset mid-measure discards all partial results.
// - prescaler_out only changes at calib_done or reset; stable at all other times.
// STRUCTURE
// - uart_pkg: state encodings (HUNT, MEASURE, WAIT_RISE, STOP_CHECK, LOCKED), DEFAULT_PRESCALER,
//   MIN_PRESCALER, shared PRESCALER_W constant used by uart_rx/uart_baud_gen/this block.
// - Sub-module uart_edge_sync: 3-flop synchronizer + fall/rise strobes (reusable by uart_rx).
// TESTING (12 MHz CLK)
// - 0x55 at 115200 (104 clk/bit) after 100 idle cycles -> calib_done, prescaler_out=104, locked=1, rx_rst_n=1.
// - 0x55 at 9600 (1250 clk/bit), then byte 0xA3 -> prescaler_out=1250, uart_rx reports rx_data=0xA3.
// - 0x55 with third low/high pair stretched to 300 clk vs d0=208 -> calib_fail, locked=0, back in HUNT.
// - 0x55 at 10 clk/bit -> cand=10<16 -> calib_fail, prescaler_out stays 104.
// - Locked; 3 framing errors without rx_ready -> locked=0; 2 errors, rx_ready, 2 errors -> stays locked.
// - rst_n low mid-MEASURE, then recal while LOCKED -> both return to HUNT; outputs at reset values/unlocked.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and the autobaud controller state encoding.
// Pure declarations: no latency, no flow control.
package uart_pkg;

    localparam int PRESCALER_W       = 21;
    localparam int DEFAULT_PRESCALER = 104;
    localparam int MIN_PRESCALER     = 16;
    localparam int IDLE_CYCLES       = 64;
    localparam int ERR_LIMIT         = 3;

    typedef enum logic [2:0] {
        ST_HUNT       = 3'd0,
        ST_MEASURE    = 3'd1,
        ST_WAIT_RISE  = 3'd2,
        ST_STOP_CHECK = 3'd3,
        ST_LOCKED     = 3'd4
    } state_t;

endpackage

// File: rtl/uart_edge_sync.sv
// 3-flop RX synchronizer with single-cycle fall/rise strobes on the synchronized line.
// Strobes appear 4 cycles after the pin edge; no backpressure (free-running).
module uart_edge_sync (
    input  logic CLK,
    input  logic rst_n,
    input  logic i_rx,
    output logic o_rx_sync,
    output logic o_fall,
    output logic o_rise
);

    logic [2:0] r_sync;
    logic       r_prev;

    // Reset to the idle (high) level so leaving reset never fakes a start edge.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_sync <= 3'b111;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[1:0], i_rx};
            r_prev <= r_sync[2];
        end
    end

    assign o_rx_sync = r_sync[2];
    assign o_fall    = r_prev & ~r_sync[2];
    assign o_rise    = ~r_prev & r_sync[2];

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Measures baud from a 0x55 sync char, programs uart_rx prescaler, holds uart_rx in reset until locked.
// Lock lands ~half a bit into the stop bit; no backpressure, all inputs sampled every cycle.
module uart_autobaud_ctrl #(
    parameter int PRESCALER_W       = 21,
    parameter int DEFAULT_PRESCALER = 104,
    parameter int MIN_PRESCALER     = 16,
    parameter int IDLE_CYCLES       = 64,
    parameter int ERR_LIMIT         = 3
) (
    input  logic                   CLK,
    input  logic                   rst_n,
    input  logic                   RX,
    input  logic                   recal,
    input  logic                   rx_ready,
    input  logic                   framing_error,
    output logic [PRESCALER_W-1:0] prescaler_out,
    output logic                   rx_rst_n,
    output logic                   locked,
    output logic                   calib_done,
    output logic                   calib_fail
);
    import uart_pkg::*;

    localparam int CW = PRESCALER_W + 3;
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);

    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);
    localparam logic [EW-1:0] ERR_LAST = EW'(ERR_LIMIT - 1);
    localparam logic [CW-1:0] CAND_MIN = CW'(MIN_PRESCALER);
    localparam logic [CW-1:0] CAND_MAX = CW'((64'd1 << PRESCALER_W) - 64'd1);

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  r_last;
    logic [CW-1:0]  r_d0;
    logic [CW-1:0]  r_cand;
    logic [CW-1:0]  r_half;
    logic [2:0]     r_edge_n;
    logic [IW-1:0]  r_idle_cnt;
    logic [EW-1:0]  r_err_cnt;
    logic           r_fe_q;

    logic           w_rx_s;
    logic           w_fall;
    logic           w_rise;
    logic [CW-1:0]  w_interval;
    logic [CW-1:0]  w_dev;
    logic           w_out_tol;
    logic           w_cnt_sat;
    logic [CW-1:0]  w_cnt_inc;
    logic           w_cand_bad;
    logic           w_fe_rise;
    logic           w_fail;

    uart_edge_sync u_edge_sync (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .i_rx      (RX),
        .o_rx_sync (w_rx_s),
        .o_fall    (w_fall),
        .o_rise    (w_rise)
    );

    assign w_interval = r_cnt - r_last;
    assign w_dev      = (w_interval > r_d0) ? (w_interval - r_d0) : (r_d0 - w_interval);
    assign w_out_tol  = w_dev > (r_d0 >> 2);
    assign w_cnt_sat  = &r_cnt;
    assign w_cnt_inc  = w_cnt_sat ? r_cnt : r_cnt + 1'b1;
    assign w_cand_bad = (r_cand < CAND_MIN) || (r_cand > CAND_MAX);
    assign w_fe_rise  = framing_error & ~r_fe_q;

    // Every way a calibration attempt can be rejected; recal abandons silently instead.
    always_comb begin
        w_fail = 1'b0;
        if (!recal) begin
            case (r_state)
                ST_MEASURE:    w_fail = w_cnt_sat || (w_fall && (r_edge_n >= 3'd2) && w_out_tol);
                ST_WAIT_RISE:  w_fail = w_cnt_sat;
                ST_STOP_CHECK: w_fail = w_fall || ((r_half == '0) && w_cand_bad);
                default:       w_fail = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_state       <= ST_HUNT;
            r_cnt         <= '0;
            r_last        <= '0;
            r_d0          <= '0;
            r_cand        <= '0;
            r_half        <= '0;
            r_edge_n      <= '0;
            r_idle_cnt    <= '0;
            r_err_cnt     <= '0;
            r_fe_q        <= 1'b0;
            prescaler_out <= PRESCALER_W'(DEFAULT_PRESCALER);
            rx_rst_n      <= 1'b0;
            locked        <= 1'b0;
            calib_done    <= 1'b0;
            calib_fail    <= 1'b0;
        end else begin
            calib_done <= 1'b0;
            calib_fail <= 1'b0;
            r_fe_q     <= framing_error;

            if (recal) begin
                r_state    <= ST_HUNT;
                r_idle_cnt <= '0;
                locked     <= 1'b0;
                rx_rst_n   <= 1'b0;
            end else if (w_fail) begin
                r_state    <= ST_HUNT;
                r_idle_cnt <= '0;
                locked     <= 1'b0;
                rx_rst_n   <= 1'b0;
                calib_fail <= 1'b1;
            end else begin
                case (r_state)
                    ST_HUNT: begin
                        if (!w_rx_s)
                            r_idle_cnt <= '0;
                        else if (r_idle_cnt != IDLE_MAX)
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                        if (w_fall && (r_idle_cnt >= IDLE_MAX)) begin
                            r_cnt    <= CW'(1);
                            r_last   <= '0;
                            r_edge_n <= 3'd1;
                            r_state  <= ST_MEASURE;
                        end
                    end
                    // cnt runs from edge 1, so its value at edge 5 is the 8-bit span.
                    ST_MEASURE: begin
                        r_cnt <= w_cnt_inc;
                        if (w_fall) begin
                            r_edge_n <= r_edge_n + 1'b1;
                            r_last   <= r_cnt;
                            if (r_edge_n == 3'd1)
                                r_d0 <= w_interval;
                            if (r_edge_n == 3'd4) begin
                                r_cand  <= r_cnt >> 3;
                                r_state <= ST_WAIT_RISE;
                            end
                        end
                    end
                    ST_WAIT_RISE: begin
                        r_cnt <= w_cnt_inc;
                        if (w_rise) begin
                            r_half  <= r_cand >> 1;
                            r_state <= ST_STOP_CHECK;
                        end
                    end
                    ST_STOP_CHECK: begin
                        if (r_half == '0) begin
                            prescaler_out <= r_cand[PRESCALER_W-1:0];
                            locked        <= 1'b1;
                            rx_rst_n      <= 1'b1;
                            calib_done    <= 1'b1;
                            r_err_cnt     <= '0;
                            r_state       <= ST_LOCKED;
                        end else begin
                            r_half <= r_half - 1'b1;
                        end
                    end
                    // A good byte proves the rate is still right, so it outranks a new error.
                    ST_LOCKED: begin
                        if (rx_ready) begin
                            r_err_cnt <= '0;
                        end else if (w_fe_rise) begin
                            if (r_err_cnt == ERR_LAST) begin
                                locked     <= 1'b0;
                                rx_rst_n   <= 1'b0;
                                r_idle_cnt <= '0;
                                r_state    <= ST_HUNT;
                            end else begin
                                r_err_cnt <= r_err_cnt + 1'b1;
                            end
                        end
                    end
                    default: r_state <= ST_HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Directed bench for uart_autobaud_ctrl: sync-char calibration, rejects, error-driven unlock, reset/recal.
module tb_uart_autobaud_ctrl;
    import uart_pkg::*;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        recal = 1'b0;
    logic        rx_ready = 1'b0;
    logic        framing_error = 1'b0;
    logic [20:0] prescaler_out;
    logic        rx_rst_n;
    logic        locked;
    logic        calib_done;
    logic        calib_fail;

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;
    int n_fail = 0;
    int done0;
    int fail0;

    always #5 CLK = ~CLK;

    uart_autobaud_ctrl dut (
        .CLK           (CLK),
        .rst_n         (rst_n),
        .RX            (RX),
        .recal         (recal),
        .rx_ready      (rx_ready),
        .framing_error (framing_error),
        .prescaler_out (prescaler_out),
        .rx_rst_n      (rx_rst_n),
        .locked        (locked),
        .calib_done    (calib_done),
        .calib_fail    (calib_fail)
    );

    always @(negedge CLK) begin
        if (calib_done === 1'b1) n_done++;
        if (calib_fail === 1'b1) n_fail++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic drive_rx(input logic lvl, input int n);
        RX = lvl;
        cyc(n);
    endtask

    task automatic send_byte(input logic [7:0] b, input int p);
        drive_rx(1'b0, p);
        for (int i = 0; i < 8; i++) drive_rx(b[i], p);
        drive_rx(1'b1, p);
    endtask

    task automatic fe_pulse();
        framing_error = 1'b1;
        cyc(2);
        framing_error = 1'b0;
        cyc(2);
    endtask

    task automatic lock_at(input int p);
        drive_rx(1'b1, 100);
        send_byte(8'h55, p);
        drive_rx(1'b1, 30);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(5);
        n_cmp++; if (prescaler_out !== 21'd104) begin n_bad++; $display("FAIL reset_presc: got %0d want 104", prescaler_out); end
        n_cmp++; if (rx_rst_n !== 1'b0) begin n_bad++; $display("FAIL reset_rx_rst_n: got %b want 0", rx_rst_n); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b want 0", locked); end
        n_cmp++; if (calib_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", calib_done); end
        n_cmp++; if (calib_fail !== 1'b0) begin n_bad++; $display("FAIL reset_fail: got %b want 0", calib_fail); end
        n_cmp++; if (dut.r_state !== ST_HUNT) begin n_bad++; $display("FAIL reset_state: got %0d want HUNT", dut.r_state); end
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_lock_115200();
        done0 = n_done; fail0 = n_fail;
        lock_at(104);
        n_cmp++; if (n_done - done0 != 1) begin n_bad++; $display("FAIL l115_done: got %0d pulses want 1", n_done - done0); end
        n_cmp++; if (n_fail - fail0 != 0) begin n_bad++; $display("FAIL l115_fail: got %0d pulses want 0", n_fail - fail0); end
        n_cmp++; if (prescaler_out !== 21'd104) begin n_bad++; $display("FAIL l115_presc: got %0d want 104", prescaler_out); end
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL l115_locked: got %b want 1", locked); end
        n_cmp++; if (rx_rst_n !== 1'b1) begin n_bad++; $display("FAIL l115_rx_rst_n: got %b want 1", rx_rst_n); end
    endtask

    task automatic test_recal_locked();
        fail0 = n_fail;
        recal = 1'b1;
        cyc(1);
        recal = 1'b0;
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL recal_locked: got %b want 0", locked); end
        n_cmp++; if (rx_rst_n !== 1'b0) begin n_bad++; $display("FAIL recal_rx_rst_n: got %b want 0", rx_rst_n); end
        n_cmp++; if (dut.r_state !== ST_HUNT) begin n_bad++; $display("FAIL recal_state: got %0d want HUNT", dut.r_state); end
        cyc(3);
        n_cmp++; if (n_fail - fail0 != 0) begin n_bad++; $display("FAIL recal_nofail: got %0d pulses want 0", n_fail - fail0); end
    endtask

    task automatic test_lock_9600_byte();
        done0 = n_done; fail0 = n_fail;
        lock_at(1250);
        n_cmp++; if (prescaler_out !== 21'd1250) begin n_bad++; $display("FAIL l9600_presc: got %0d want 1250", prescaler_out); end
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL l9600_locked: got %b want 1", locked); end
        send_byte(8'hA3, 1250);
        drive_rx(1'b1, 20);
        n_cmp++; if (prescaler_out !== 21'd1250) begin n_bad++; $display("FAIL a3_presc: got %0d want 1250", prescaler_out); end
        n_cmp++; if (locked !== 1'b1 || rx_rst_n !== 1'b1) begin n_bad++; $display("FAIL a3_locked: got locked=%b rx_rst_n=%b want 1/1", locked, rx_rst_n); end
        n_cmp++; if (n_done - done0 != 1) begin n_bad++; $display("FAIL a3_done: got %0d pulses want 1", n_done - done0); end
    endtask

    task automatic test_reset_mid_measure();
        recal = 1'b1;
        cyc(1);
        recal = 1'b0;
        drive_rx(1'b1, 100);
        drive_rx(1'b0, 104);
        drive_rx(1'b1, 104);
        drive_rx(1'b0, 104);
        n_cmp++; if (dut.r_state !== ST_MEASURE) begin n_bad++; $display("FAIL mid_state: got %0d want MEASURE", dut.r_state); end
        rst_n = 1'b0;
        recal = 1'b1;
        cyc(2);
        n_cmp++; if (prescaler_out !== 21'd104) begin n_bad++; $display("FAIL mid_presc: got %0d want 104", prescaler_out); end
        n_cmp++; if (locked !== 1'b0 || rx_rst_n !== 1'b0) begin n_bad++; $display("FAIL mid_unlocked: got locked=%b rx_rst_n=%b want 0/0", locked, rx_rst_n); end
        n_cmp++; if (dut.r_state !== ST_HUNT) begin n_bad++; $display("FAIL mid_state_rst: got %0d want HUNT", dut.r_state); end
        rst_n = 1'b1;
        recal = 1'b0;
        drive_rx(1'b1, 10);
    endtask

    task automatic test_stretched();
        done0 = n_done; fail0 = n_fail;
        drive_rx(1'b1, 100);
        drive_rx(1'b0, 104);
        drive_rx(1'b1, 104);
        drive_rx(1'b0, 104);
        drive_rx(1'b1, 104);
        drive_rx(1'b0, 150);
        drive_rx(1'b1, 150);
        drive_rx(1'b0, 104);
        n_cmp++; if (n_fail - fail0 != 1) begin n_bad++; $display("FAIL stretch_fail: got %0d pulses want 1", n_fail - fail0); end
        n_cmp++; if (n_done - done0 != 0) begin n_bad++; $display("FAIL stretch_done: got %0d pulses want 0", n_done - done0); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL stretch_locked: got %b want 0", locked); end
        n_cmp++; if (dut.r_state !== ST_HUNT) begin n_bad++; $display("FAIL stretch_state: got %0d want HUNT", dut.r_state); end
        drive_rx(1'b1, 20);
    endtask

    task automatic test_min_prescaler();
        done0 = n_done; fail0 = n_fail;
        lock_at(10);
        n_cmp++; if (n_fail - fail0 != 1) begin n_bad++; $display("FAIL min_fail: got %0d pulses want 1", n_fail - fail0); end
        n_cmp++; if (n_done - done0 != 0) begin n_bad++; $display("FAIL min_done: got %0d pulses want 0", n_done - done0); end
        n_cmp++; if (prescaler_out !== 21'd104) begin n_bad++; $display("FAIL min_presc: got %0d want 104", prescaler_out); end
        n_cmp++; if (locked !== 1'b0 || rx_rst_n !== 1'b0) begin n_bad++; $display("FAIL min_unlocked: got locked=%b rx_rst_n=%b want 0/0", locked, rx_rst_n); end
    endtask

    task automatic test_framing_errors();
        lock_at(104);
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL fe_prelock: got %b want 1", locked); end
        fe_pulse();
        fe_pulse();
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL fe_two: got %b want 1", locked); end
        fe_pulse();
        n_cmp++; if (locked !== 1'b0 || rx_rst_n !== 1'b0) begin n_bad++; $display("FAIL fe_three: got locked=%b rx_rst_n=%b want 0/0", locked, rx_rst_n); end
        n_cmp++; if (prescaler_out !== 21'd104) begin n_bad++; $display("FAIL fe_presc: got %0d want 104", prescaler_out); end

        lock_at(104);
        fe_pulse();
        fe_pulse();
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
        fe_pulse();
        fe_pulse();
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL fe_ready_clear: got %b want 1", locked); end
        // err_cnt is 2 here; a rise coinciding with rx_ready must still clear it.
        rx_ready = 1'b1;
        framing_error = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
        cyc(1);
        framing_error = 1'b0;
        cyc(2);
        fe_pulse();
        fe_pulse();
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL fe_same_cycle: got %b want 1", locked); end
        fe_pulse();
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL fe_after_same: got %b want 0", locked); end
    endtask

    initial begin
        test_reset();
        test_lock_115200();
        test_recal_locked();
        test_lock_9600_byte();
        test_reset_mid_measure();
        test_stretched();
        test_min_prescaler();
        test_framing_errors();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
